// File: rtl/eq_sequencer_if.sv
// Handshake/control bundle between the equalizer sequencer and its neighbours
// (packet detect, channel estimation, data FFT, channel_equalize datapath).
interface eq_sequencer_if #(
   parameter int IDXW = 4
);
   logic            pkt_detect_i;
   logic            channel_est_valid_i;
   logic            datasymbol_valid_i;
   logic            fft_valid_i;
   logic            abort_i;
   logic            ch_load_o;
   logic            fft_start_o;
   logic            coef_ready_o;
   logic            eq_valid_o;
   logic [IDXW-1:0] sym_idx_o;
   logic            pkt_done_o;
   logic            busy_o;
   logic            err_o;

   modport slave (
      input  pkt_detect_i, channel_est_valid_i, datasymbol_valid_i, fft_valid_i, abort_i,
      output ch_load_o, fft_start_o, coef_ready_o, eq_valid_o, sym_idx_o, pkt_done_o,
             busy_o, err_o
   );

   modport master (
      output pkt_detect_i, channel_est_valid_i, datasymbol_valid_i, fft_valid_i, abort_i,
      input  ch_load_o, fft_start_o, coef_ready_o, eq_valid_o, sym_idx_o, pkt_done_o,
             busy_o, err_o
   );
endinterface

// File: rtl/eq_sequencer.sv
// Control sequencer for the zero-forcing equalizer: arms on packet detect, times the
// reciprocal pipeline, gates data-FFT starts and tags each retired symbol with its index.
module eq_sequencer #(
   parameter int NUMSYMBS  = 12,
   parameter int RECIP_LAT = 11,
   parameter int TIMEOUT   = 1024,
   parameter int IDXW      = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   eq_sequencer_if.slave bus
);
   localparam int LATW = $clog2(RECIP_LAT + 1);
   localparam int TOW  = $clog2(TIMEOUT);
   localparam int CW   = $clog2(NUMSYMBS + 1);

   localparam logic [LATW-1:0] LAT_INIT = LATW'(RECIP_LAT);
   localparam logic [LATW-1:0] LAT_ONE  = LATW'(1);
   localparam logic [TOW-1:0]  TO_MAX   = TOW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   NSYM     = CW'(NUMSYMBS);
   localparam logic [CW-1:0]   LAST     = CW'(NUMSYMBS - 1);

   typedef enum logic [1:0] {IDLE, WAIT_CH, RECIP, EQZ} state_t;

   // Reset asserts immediately, releases two clocks after rst_i rises.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   state_t          state_q;
   logic [LATW-1:0] lat_cnt_q;
   logic [TOW-1:0]  to_cnt_q;
   logic [CW-1:0]   iss_cnt_q;
   logic [CW-1:0]   ret_cnt_q;
   logic            ch_load_q, fft_start_q, coef_ready_q, eq_valid_q;
   logic            pkt_done_q, busy_q, err_q;
   logic [IDXW-1:0] sym_idx_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         to_cnt_q     <= '0;
         iss_cnt_q    <= '0;
         ret_cnt_q    <= '0;
         ch_load_q    <= 1'b0;
         fft_start_q  <= 1'b0;
         coef_ready_q <= 1'b0;
         eq_valid_q   <= 1'b0;
         sym_idx_q    <= '0;
         pkt_done_q   <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         ch_load_q   <= 1'b0;
         fft_start_q <= 1'b0;
         eq_valid_q  <= 1'b0;
         pkt_done_q  <= 1'b0;
         err_q       <= 1'b0;
         if (bus.abort_i) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            to_cnt_q     <= '0;
            iss_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            coef_ready_q <= 1'b0;
            busy_q       <= 1'b0;
         end else begin
            // Data symbols may enter the FFT as soon as the reciprocals are in flight.
            if ((state_q == RECIP || state_q == EQZ) && bus.datasymbol_valid_i &&
                (iss_cnt_q < NSYM)) begin
               fft_start_q <= 1'b1;
               iss_cnt_q   <= iss_cnt_q + CW'(1);
            end
            case (state_q)
               IDLE: begin
                  if (bus.pkt_detect_i) begin
                     state_q   <= WAIT_CH;
                     busy_q    <= 1'b1;
                     lat_cnt_q <= '0;
                     to_cnt_q  <= '0;
                     iss_cnt_q <= '0;
                     ret_cnt_q <= '0;
                  end
               end
               WAIT_CH: begin
                  if (bus.channel_est_valid_i) begin
                     ch_load_q <= 1'b1;
                     state_q   <= RECIP;
                     lat_cnt_q <= LAT_INIT;
                     to_cnt_q  <= '0;
                  end else if (to_cnt_q == TO_MAX) begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     to_cnt_q <= to_cnt_q + TOW'(1);
                  end
               end
               RECIP: begin
                  // An FFT output before the coefficients exist cannot be equalized.
                  if (bus.fft_valid_i) err_q <= 1'b1;
                  if (lat_cnt_q == LAT_ONE) begin
                     lat_cnt_q    <= '0;
                     coef_ready_q <= 1'b1;
                     state_q      <= EQZ;
                  end else begin
                     lat_cnt_q <= lat_cnt_q - LATW'(1);
                  end
               end
               EQZ: begin
                  if (bus.fft_valid_i) begin
                     eq_valid_q <= 1'b1;
                     sym_idx_q  <= IDXW'(ret_cnt_q);
                     ret_cnt_q  <= ret_cnt_q + CW'(1);
                     to_cnt_q   <= '0;
                     if (ret_cnt_q == LAST) begin
                        pkt_done_q   <= 1'b1;
                        coef_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                     end
                  end else if (to_cnt_q == TO_MAX) begin
                     err_q        <= 1'b1;
                     coef_ready_q <= 1'b0;
                     busy_q       <= 1'b0;
                     state_q      <= IDLE;
                  end else begin
                     to_cnt_q <= to_cnt_q + TOW'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.ch_load_o    = ch_load_q;
   assign bus.fft_start_o  = fft_start_q;
   assign bus.coef_ready_o = coef_ready_q;
   assign bus.eq_valid_o   = eq_valid_q;
   assign bus.sym_idx_o    = sym_idx_q;
   assign bus.pkt_done_o   = pkt_done_q;
   assign bus.busy_o       = busy_q;
   assign bus.err_o        = err_q;
endmodule

// File: tb/tb_eq_sequencer.sv
// Scenario bench for eq_sequencer: a 22-cycle FFT model answers fft_start_o, and a
// scoreboard queue holds the index/done tag expected for every retired symbol.
module tb_eq_sequencer;
   localparam int NUMSYMBS  = 12;
   localparam int RECIP_LAT = 11;
   localparam int TIMEOUT   = 1024;
   localparam int IDXW      = 4;
   localparam int FFT_LAT   = 22;

   typedef struct {int idx; bit done;} exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   eq_sequencer_if #(.IDXW(IDXW)) bus ();

   eq_sequencer #(
      .NUMSYMBS (NUMSYMBS),
      .RECIP_LAT(RECIP_LAT),
      .TIMEOUT  (TIMEOUT),
      .IDXW     (IDXW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.pkt_detect_i        = 1'b0;
      bus.channel_est_valid_i = 1'b0;
      bus.datasymbol_valid_i  = 1'b0;
      bus.fft_valid_i         = 1'b0;
      bus.abort_i             = 1'b0;
   endtask

   task automatic test_reset();
      logic [IDXW+6:0] outs;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      outs = {bus.ch_load_o, bus.fft_start_o, bus.coef_ready_o, bus.eq_valid_o,
              bus.pkt_done_o, bus.busy_o, bus.err_o, bus.sym_idx_o};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%0h exp=0", outs);
      end
      #2 rst_n = 1'b1;
      repeat (3) tick();
      total++;
      if (bus.busy_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_busy got=%0b exp=0", bus.busy_o);
      end
   endtask

   // Full packet with nsym data symbols; fewer than NUMSYMBS ends in an EQZ timeout.
   task automatic test_packet(input int nsym);
      int   fft_q[$];
      exp_t sb[$];
      exp_t ent;
      int   issued = 0, pushed = 0, neq = 0;
      int   nret = (nsym < NUMSYMBS) ? nsym : NUMSYMBS;
      int   last_fft = 3 + 5 * (nret - 1) + FFT_LAT;
      int   end_evt = (nsym < NUMSYMBS) ? last_fft + TIMEOUT : last_fft;
      bit   exp_fs, exp_eqv, exp_done;
      for (int e = 0; e <= end_evt + 6; e++) begin
         idle_in();
         bus.pkt_detect_i        = (e == 0);
         bus.channel_est_valid_i = (e == 2);
         bus.datasymbol_valid_i  = (e >= 3) && ((e - 3) % 5 == 0) && ((e - 3) / 5 < nsym);
         exp_fs = bus.datasymbol_valid_i && (issued < NUMSYMBS);
         if (exp_fs) issued++;
         if (fft_q.size() > 0 && fft_q[0] == e) begin
            void'(fft_q.pop_front());
            bus.fft_valid_i = 1'b1;
            sb.push_back('{pushed, pushed == NUMSYMBS - 1});
            pushed++;
         end
         exp_eqv = bus.fft_valid_i;
         tick();
         if (bus.fft_start_o === 1'b1) fft_q.push_back(e + FFT_LAT);
         total++;
         if (bus.fft_start_o !== exp_fs) begin
            bad++;
            $display("FAIL fft_start n=%0d e=%0d got=%0b exp=%0b", nsym, e, bus.fft_start_o, exp_fs);
         end
         total++;
         if (bus.ch_load_o !== (e == 2)) begin
            bad++;
            $display("FAIL ch_load n=%0d e=%0d got=%0b exp=%0b", nsym, e, bus.ch_load_o, e == 2);
         end
         total++;
         if (bus.busy_o !== (e < end_evt)) begin
            bad++;
            $display("FAIL busy n=%0d e=%0d got=%0b exp=%0b", nsym, e, bus.busy_o, e < end_evt);
         end
         total++;
         if (bus.coef_ready_o !== (e >= 2 + RECIP_LAT && e < end_evt)) begin
            bad++;
            $display("FAIL coef_ready n=%0d e=%0d got=%0b", nsym, e, bus.coef_ready_o);
         end
         total++;
         if (bus.err_o !== (nsym < NUMSYMBS && e == end_evt)) begin
            bad++;
            $display("FAIL err n=%0d e=%0d got=%0b", nsym, e, bus.err_o);
         end
         total++;
         if (bus.eq_valid_o !== exp_eqv) begin
            bad++;
            $display("FAIL eq_valid n=%0d e=%0d got=%0b exp=%0b", nsym, e, bus.eq_valid_o, exp_eqv);
         end
         exp_done = 1'b0;
         if (bus.eq_valid_o === 1'b1) begin
            neq++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow n=%0d e=%0d got=eq_valid exp=none", nsym, e);
            end else begin
               ent = sb.pop_front();
               exp_done = ent.done;
               total++;
               if (bus.sym_idx_o !== IDXW'(ent.idx)) begin
                  bad++;
                  $display("FAIL sym_idx n=%0d e=%0d got=%0d exp=%0d", nsym, e, bus.sym_idx_o, ent.idx);
               end
            end
         end
         total++;
         if (bus.pkt_done_o !== exp_done) begin
            bad++;
            $display("FAIL pkt_done n=%0d e=%0d got=%0b exp=%0b", nsym, e, bus.pkt_done_o, exp_done);
         end
      end
      idle_in();
      total++;
      if (neq != nret) begin
         bad++;
         $display("FAIL retired_count n=%0d got=%0d exp=%0d", nsym, neq, nret);
      end
      total++;
      if (issued != nret || sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover n=%0d got=%0d exp=0", nsym, sb.size());
      end
   endtask

   task automatic test_late_coef();
      exp_t sb[$];
      exp_t ent;
      for (int e = 0; e <= 21; e++) begin
         idle_in();
         bus.pkt_detect_i        = (e == 0);
         bus.channel_est_valid_i = (e == 2);
         bus.fft_valid_i         = (e == 5) || (e == 16);
         bus.abort_i             = (e == 18);
         if (e == 16) sb.push_back('{0, 1'b0});
         tick();
         total++;
         if (bus.err_o !== (e == 5)) begin
            bad++;
            $display("FAIL late_err e=%0d got=%0b exp=%0b", e, bus.err_o, e == 5);
         end
         total++;
         if (bus.eq_valid_o !== (e == 16)) begin
            bad++;
            $display("FAIL late_eq_valid e=%0d got=%0b exp=%0b", e, bus.eq_valid_o, e == 16);
         end
         if (bus.eq_valid_o === 1'b1 && sb.size() > 0) begin
            ent = sb.pop_front();
            total++;
            if (bus.sym_idx_o !== IDXW'(ent.idx)) begin
               bad++;
               $display("FAIL late_sym_idx e=%0d got=%0d exp=%0d", e, bus.sym_idx_o, ent.idx);
            end
         end
         total++;
         if (bus.coef_ready_o !== (e >= 13 && e < 18) || bus.busy_o !== (e < 18)) begin
            bad++;
            $display("FAIL late_levels e=%0d got=%0b%0b", e, bus.coef_ready_o, bus.busy_o);
         end
      end
      idle_in();
   endtask

   task automatic test_timeout_wait();
      for (int e = 0; e <= TIMEOUT + 6; e++) begin
         idle_in();
         bus.pkt_detect_i = (e == 0);
         tick();
         total++;
         if (bus.err_o !== (e == TIMEOUT)) begin
            bad++;
            $display("FAIL wait_timeout_err e=%0d got=%0b exp=%0b", e, bus.err_o, e == TIMEOUT);
         end
         total++;
         if (bus.busy_o !== (e < TIMEOUT) || bus.ch_load_o !== 1'b0) begin
            bad++;
            $display("FAIL wait_timeout_busy e=%0d got=%0b", e, bus.busy_o);
         end
      end
      idle_in();
   endtask

   // Abort lands on the cycle symbol 6 comes out of the FFT.
   task automatic test_abort();
      int   fft_q[$];
      exp_t sb[$];
      exp_t ent;
      int   pushed = 0;
      bit   exp_eqv;
      for (int e = 0; e <= 60; e++) begin
         idle_in();
         bus.pkt_detect_i        = (e == 0);
         bus.channel_est_valid_i = (e == 2);
         bus.datasymbol_valid_i  = (e >= 3) && (e < 55) && ((e - 3) % 5 == 0);
         bus.abort_i             = (e == 55);
         if (e <= 55 && fft_q.size() > 0 && fft_q[0] == e) begin
            void'(fft_q.pop_front());
            bus.fft_valid_i = 1'b1;
            if (e != 55) sb.push_back('{pushed, 1'b0});
            pushed++;
         end
         exp_eqv = bus.fft_valid_i && !bus.abort_i;
         tick();
         if (bus.fft_start_o === 1'b1) fft_q.push_back(e + FFT_LAT);
         total++;
         if (bus.eq_valid_o !== exp_eqv) begin
            bad++;
            $display("FAIL abort_eq_valid e=%0d got=%0b exp=%0b", e, bus.eq_valid_o, exp_eqv);
         end
         if (bus.eq_valid_o === 1'b1 && sb.size() > 0) begin
            ent = sb.pop_front();
            total++;
            if (bus.sym_idx_o !== IDXW'(ent.idx)) begin
               bad++;
               $display("FAIL abort_sym_idx e=%0d got=%0d exp=%0d", e, bus.sym_idx_o, ent.idx);
            end
         end
         total++;
         if (bus.busy_o !== (e < 55) || bus.coef_ready_o !== (e >= 13 && e < 55)) begin
            bad++;
            $display("FAIL abort_levels e=%0d got=%0b%0b", e, bus.busy_o, bus.coef_ready_o);
         end
         total++;
         if (bus.err_o !== 1'b0 || bus.pkt_done_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulses e=%0d got=%0b%0b exp=00", e, bus.err_o, bus.pkt_done_o);
         end
      end
      idle_in();
      total++;
      if (pushed != 7) begin
         bad++;
         $display("FAIL abort_symbol got=%0d exp=7", pushed);
      end
   endtask

   task automatic test_reset_mid();
      int              fft_q[$];
      logic [IDXW+6:0] outs;
      for (int e = 0; e <= 40; e++) begin
         idle_in();
         bus.pkt_detect_i        = (e == 0);
         bus.channel_est_valid_i = (e == 2);
         bus.datasymbol_valid_i  = (e >= 3) && ((e - 3) % 5 == 0);
         if (fft_q.size() > 0 && fft_q[0] == e) begin
            void'(fft_q.pop_front());
            bus.fft_valid_i = 1'b1;
         end
         tick();
         if (bus.fft_start_o === 1'b1) fft_q.push_back(e + FFT_LAT);
      end
      idle_in();
      total++;
      if (bus.busy_o !== 1'b1 || bus.coef_ready_o !== 1'b1 || bus.eq_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL mid_eqz_state got=%0b%0b%0b exp=111", bus.busy_o, bus.coef_ready_o, bus.eq_valid_o);
      end
      rst_n = 1'b0;
      #2;
      outs = {bus.ch_load_o, bus.fft_start_o, bus.coef_ready_o, bus.eq_valid_o,
              bus.pkt_done_o, bus.busy_o, bus.err_o, bus.sym_idx_o};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL async_reset_outputs got=%0h exp=0", outs);
      end
      #1 rst_n = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle_in();
      test_reset();
      test_packet(12);
      test_packet(14);
      test_late_coef();
      test_timeout_wait();
      test_packet(5);
      test_abort();
      test_packet(12);
      test_reset_mid();
      test_packet(12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
